// File: rtl/bsg_manycore_profile_pkg.sv
// Shared types for the SAIF capture-window controller.
package bsg_manycore_profile_pkg;

    // Controller phases: waiting for a first start, capturing, waiting for the report writer.
    typedef enum logic [1:0] {
        SAIF_IDLE   = 2'd0,
        SAIF_ACTIVE = 2'd1,
        SAIF_DUMP   = 2'd2
    } saif_ctrl_state_e;

    localparam int saif_state_width_lp = 2;

endpackage

// File: rtl/bsg_popcount.sv
// Combinational population count of a bit vector.
module bsg_popcount #(
    parameter int width_p = 16
) (
    input  logic [width_p-1:0]             data_i,
    output logic [$clog2(width_p+1)-1:0]   count_o
);

    localparam int count_width_lp = $clog2(width_p+1);

    // Sum every bit of the input vector.
    always_comb begin
        count_o = '0;
        for (int k = 0; k < width_p; k++) begin
            count_o = count_o + count_width_lp'(data_i[k]);
        end
    end

endmodule

// File: rtl/saif_window_ctrl.sv
// SAIF capture-window controller: tracks which tiles are inside a window,
// opens a toggle-capture window on the first start, closes it when the last
// tile ends, and waits for the report writer before accepting a new window.
//
// Handshake: start_v_i/end_v_i are single-cycle per-tile pulses with no
// back-pressure; dump_done_i is a single-cycle acknowledgement that is only
// honoured while the controller is in DUMP. Every output is registered, so
// any input effect shows up exactly one cycle later.
module saif_window_ctrl
    import bsg_manycore_profile_pkg::*;
#(
    parameter int num_tiles_p       = 16,
    parameter int cycle_width_p     = 32,
    parameter int window_id_width_p = 8
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [num_tiles_p-1:0]              start_v_i,
    input  logic [num_tiles_p-1:0]              end_v_i,
    input  logic                                dump_done_i,
    output logic                                toggle_start_o,
    output logic                                toggle_stop_o,
    output logic                                saif_en_o,
    output logic [$clog2(num_tiles_p+1)-1:0]    active_tiles_o,
    output logic [cycle_width_p-1:0]            window_cycles_o,
    output logic [window_id_width_p-1:0]        window_id_o,
    output logic                                err_unmatched_o,
    output logic                                err_dropped_o,
    output logic [saif_state_width_lp-1:0]      debug_state_o
);

    localparam int count_width_lp = $clog2(num_tiles_p+1);

    saif_ctrl_state_e           state_r, state_n;
    logic [num_tiles_p-1:0]     active_r, active_n;
    logic [num_tiles_p-1:0]     start_only, end_only;
    logic [num_tiles_p-1:0]     set_mask, clr_mask;
    logic                       unmatched, dropped;
    logic                       open_window, close_window, finish_dump;
    logic [count_width_lp-1:0]  count_n;

    bsg_popcount #(
        .width_p (num_tiles_p)
    ) popcount (
        .data_i  (active_n),
        .count_o (count_n)
    );

    // Per-tile trigger decode: simultaneous start+end cancels; DUMP blocks all updates.
    always_comb begin
        start_only = start_v_i & ~end_v_i;
        end_only   = end_v_i & ~start_v_i;
        set_mask   = '0;
        clr_mask   = '0;
        unmatched  = 1'b0;
        dropped    = 1'b0;
        if (state_r == SAIF_DUMP) begin
            dropped   = |start_only;
            unmatched = |end_only;
        end else begin
            set_mask  = start_only & ~active_r;
            clr_mask  = end_only & active_r;
            unmatched = |(end_only & ~active_r);
        end
        active_n = (active_r | set_mask) & ~clr_mask;
    end

    // Window FSM next-state and transition strobes.
    always_comb begin
        state_n      = state_r;
        open_window  = 1'b0;
        close_window = 1'b0;
        finish_dump  = 1'b0;
        case (state_r)
            SAIF_IDLE: begin
                if (|set_mask) begin
                    state_n     = SAIF_ACTIVE;
                    open_window = 1'b1;
                end
            end
            SAIF_ACTIVE: begin
                if (active_n == '0) begin
                    state_n      = SAIF_DUMP;
                    close_window = 1'b1;
                end
            end
            SAIF_DUMP: begin
                if (dump_done_i) begin
                    state_n     = SAIF_IDLE;
                    finish_dump = 1'b1;
                end
            end
            default: state_n = SAIF_IDLE;
        endcase
    end

    // FSM state and per-tile active vector.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r  <= SAIF_IDLE;
            active_r <= '0;
        end else begin
            state_r  <= state_n;
            active_r <= active_n;
        end
    end

    // Registered outputs, sticky errors, window cycle counter and window index.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            toggle_start_o  <= 1'b0;
            toggle_stop_o   <= 1'b0;
            saif_en_o       <= 1'b0;
            active_tiles_o  <= '0;
            window_cycles_o <= '0;
            window_id_o     <= '0;
            err_unmatched_o <= 1'b0;
            err_dropped_o   <= 1'b0;
        end else begin
            toggle_start_o <= open_window;
            toggle_stop_o  <= close_window;
            saif_en_o      <= (state_n == SAIF_ACTIVE);
            active_tiles_o <= count_n;
            if (unmatched) begin
                err_unmatched_o <= 1'b1;
            end
            if (dropped) begin
                err_dropped_o <= 1'b1;
            end
            if (open_window) begin
                window_cycles_o <= '0;
            end else if ((state_r == SAIF_ACTIVE) && (window_cycles_o != '1)) begin
                window_cycles_o <= window_cycles_o + cycle_width_p'(1);
            end
            if (finish_dump) begin
                window_id_o <= window_id_o + window_id_width_p'(1);
            end
        end
    end

    assign debug_state_o = state_r;

endmodule

// File: tb/tb_saif_window_ctrl.sv
// Bench for saif_window_ctrl: a reference model predicts every output each
// cycle into a scoreboard queue, and scenario tasks add targeted checks.
module tb_saif_window_ctrl;

    localparam int N  = 16;
    localparam int CW = 5;
    localparam int IW = 2;
    localparam int W  = 19;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DUMP   = 2'd2;
    localparam logic [N-1:0] NONE   = '0;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  start_v, end_v;
    logic          dump_done;
    logic          toggle_start_o, toggle_stop_o, saif_en_o;
    logic [4:0]    active_tiles_o;
    logic [CW-1:0] window_cycles_o;
    logic [IW-1:0] window_id_o;
    logic          err_unmatched_o, err_dropped_o;
    logic [1:0]    debug_state_o;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    // reference model state
    logic [1:0]    m_state = S_IDLE;
    logic [N-1:0]  m_act = '0;
    logic [CW-1:0] m_cycles = '0;
    logic [IW-1:0] m_id = '0;
    logic          m_eu = 1'b0, m_ed = 1'b0, m_start = 1'b0, m_stop = 1'b0;

    saif_window_ctrl #(
        .num_tiles_p       (N),
        .cycle_width_p     (CW),
        .window_id_width_p (IW)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (rst_n),
        .start_v_i       (start_v),
        .end_v_i         (end_v),
        .dump_done_i     (dump_done),
        .toggle_start_o  (toggle_start_o),
        .toggle_stop_o   (toggle_stop_o),
        .saif_en_o       (saif_en_o),
        .active_tiles_o  (active_tiles_o),
        .window_cycles_o (window_cycles_o),
        .window_id_o     (window_id_o),
        .err_unmatched_o (err_unmatched_o),
        .err_dropped_o   (err_dropped_o),
        .debug_state_o   (debug_state_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_n     = 1'b0;
        start_v   = '0;
        end_v     = '0;
        dump_done = 1'b0;
    end

    // scoreboard: one expected entry per driven cycle, compared after the edge
    always @(posedge clk) begin
        logic [W-1:0] got, exp;
        #1;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = {toggle_start_o, toggle_stop_o, saif_en_o, active_tiles_o, window_cycles_o,
                   window_id_o, err_unmatched_o, err_dropped_o, debug_state_o};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got start=%b stop=%b en=%b cnt=%0d cyc=%0d id=%0d eu=%b ed=%b st=%0d required start=%b stop=%b en=%b cnt=%0d cyc=%0d id=%0d eu=%b ed=%b st=%0d",
                         $time, got[18], got[17], got[16], got[15:11], got[10:6], got[5:4], got[3], got[2], got[1:0],
                         exp[18], exp[17], exp[16], exp[15:11], exp[10:6], exp[5:4], exp[3], exp[2], exp[1:0]);
            end
        end
    end

    // driver: apply one cycle of stimulus and predict the registered result
    task automatic drive(input logic rn, input logic [N-1:0] s, input logic [N-1:0] e, input logic d);
        logic       started;
        logic [1:0] old;
        @(negedge clk);
        rst_n     = rn;
        start_v   = s;
        end_v     = e;
        dump_done = d;
        m_start   = 1'b0;
        m_stop    = 1'b0;
        if (!rn) begin
            m_state  = S_IDLE;
            m_act    = '0;
            m_cycles = '0;
            m_id     = '0;
            m_eu     = 1'b0;
            m_ed     = 1'b0;
        end else begin
            old     = m_state;
            started = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (s[i] && !e[i]) begin
                    if (old == S_DUMP) m_ed = 1'b1;
                    else if (!m_act[i]) begin
                        m_act[i] = 1'b1;
                        started  = 1'b1;
                    end
                end else if (e[i] && !s[i]) begin
                    if (old == S_DUMP) m_eu = 1'b1;
                    else if (m_act[i]) m_act[i] = 1'b0;
                    else m_eu = 1'b1;
                end
            end
            if (old == S_IDLE && started) begin
                m_state  = S_ACTIVE;
                m_start  = 1'b1;
                m_cycles = '0;
            end else if (old == S_ACTIVE) begin
                if (m_cycles != 5'd31) m_cycles = m_cycles + 5'd1;
                if (m_act == '0) begin
                    m_state = S_DUMP;
                    m_stop  = 1'b1;
                end
            end else if (old == S_DUMP && d) begin
                m_state = S_IDLE;
                m_id    = m_id + 2'd1;
            end
        end
        exp_q.push_back({m_start, m_stop, (m_state == S_ACTIVE), 5'($countones(m_act)), m_cycles,
                         m_id, m_eu, m_ed, m_state});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, NONE, NONE, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, NONE, NONE, 1'b0);
        drive(1'b0, NONE, NONE, 1'b0);
    endtask

    function automatic logic [N-1:0] tile(input int i);
        logic [N-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic observe();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        observe();
        checks++;
        if ({toggle_start_o, toggle_stop_o, saif_en_o, err_unmatched_o, err_dropped_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000",
                     {toggle_start_o, toggle_stop_o, saif_en_o, err_unmatched_o, err_dropped_o});
        end
        checks++;
        if (active_tiles_o !== 0 || window_cycles_o !== 0 || window_id_o !== 0 || debug_state_o !== S_IDLE) begin
            errors++;
            $display("FAIL reset_values: got cnt=%0d cyc=%0d id=%0d st=%0d required all 0",
                     active_tiles_o, window_cycles_o, window_id_o, debug_state_o);
        end
    endtask

    task automatic test_single_window();
        do_reset();
        idle(10);
        drive(1'b1, tile(3), NONE, 1'b0);
        observe();
        checks++;
        if (toggle_start_o !== 1'b1 || saif_en_o !== 1'b1) begin
            errors++;
            $display("FAIL single_start: got start=%b en=%b required 1 1", toggle_start_o, saif_en_o);
        end
        idle(9);
        drive(1'b1, NONE, tile(3), 1'b0);
        observe();
        checks++;
        if (toggle_stop_o !== 1'b1 || window_cycles_o !== 10 || window_id_o !== 0) begin
            errors++;
            $display("FAIL single_stop: got stop=%b cyc=%0d id=%0d required 1 10 0",
                     toggle_stop_o, window_cycles_o, window_id_o);
        end
        idle(2);
        drive(1'b1, NONE, NONE, 1'b1);
        observe();
        checks++;
        if (window_id_o !== 1 || debug_state_o !== S_IDLE || window_cycles_o !== 10) begin
            errors++;
            $display("FAIL single_done: got id=%0d st=%0d cyc=%0d required 1 0 10",
                     window_id_o, debug_state_o, window_cycles_o);
        end
    endtask

    task automatic test_two_tiles();
        int n_start, n_stop;
        logic [N-1:0] s, e;
        n_start = 0;
        n_stop  = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            s = (c == 0) ? (tile(0) | tile(5)) : NONE;
            e = (c == 4) ? tile(0) : ((c == 9) ? tile(5) : NONE);
            drive(1'b1, s, e, 1'b0);
            observe();
            n_start += int'(toggle_start_o);
            n_stop  += int'(toggle_stop_o);
            if (c == 0 || c == 4 || c == 9) begin
                checks++;
                if (active_tiles_o !== ((c == 0) ? 5'd2 : ((c == 4) ? 5'd1 : 5'd0))) begin
                    errors++;
                    $display("FAIL two_tiles_count c=%0d: got %0d", c, active_tiles_o);
                end
            end
        end
        checks++;
        if (n_start != 1 || n_stop != 1) begin
            errors++;
            $display("FAIL two_tiles_pulses: got start=%0d stop=%0d required 1 1", n_start, n_stop);
        end
        drive(1'b1, NONE, NONE, 1'b1);
    endtask

    task automatic test_handover();
        do_reset();
        drive(1'b1, tile(1), NONE, 1'b0);
        idle(2);
        drive(1'b1, tile(2), tile(1), 1'b0);
        observe();
        checks++;
        if (toggle_stop_o !== 1'b0 || active_tiles_o !== 1 || debug_state_o !== S_ACTIVE) begin
            errors++;
            $display("FAIL handover: got stop=%b cnt=%0d st=%0d required 0 1 1",
                     toggle_stop_o, active_tiles_o, debug_state_o);
        end
        drive(1'b1, NONE, tile(2), 1'b0);
        observe();
        checks++;
        if (toggle_stop_o !== 1'b1) begin
            errors++;
            $display("FAIL handover_close: got stop=%b required 1", toggle_stop_o);
        end
        drive(1'b1, NONE, NONE, 1'b1);
    endtask

    task automatic test_simul_start_end();
        do_reset();
        drive(1'b1, tile(7), tile(7), 1'b0);
        observe();
        checks++;
        if ({toggle_start_o, toggle_stop_o, err_unmatched_o, err_dropped_o} !== 4'b0 ||
            debug_state_o !== S_IDLE || active_tiles_o !== 0) begin
            errors++;
            $display("FAIL simul_start_end: got flags=%b st=%0d cnt=%0d required 0000 0 0",
                     {toggle_start_o, toggle_stop_o, err_unmatched_o, err_dropped_o},
                     debug_state_o, active_tiles_o);
        end
    endtask

    task automatic test_errors();
        do_reset();
        drive(1'b1, tile(0), NONE, 1'b0);
        drive(1'b1, NONE, tile(0), 1'b0);
        drive(1'b1, tile(4), NONE, 1'b0);
        observe();
        checks++;
        if (err_dropped_o !== 1'b1 || err_unmatched_o !== 1'b0 || active_tiles_o !== 0 || debug_state_o !== S_DUMP) begin
            errors++;
            $display("FAIL dropped_start: got ed=%b eu=%b cnt=%0d st=%0d required 1 0 0 2",
                     err_dropped_o, err_unmatched_o, active_tiles_o, debug_state_o);
        end
        drive(1'b1, NONE, NONE, 1'b1);
        drive(1'b1, NONE, tile(6), 1'b0);
        observe();
        checks++;
        if (err_unmatched_o !== 1'b1 || active_tiles_o !== 0 || debug_state_o !== S_IDLE) begin
            errors++;
            $display("FAIL unmatched_end: got eu=%b cnt=%0d st=%0d required 1 0 0",
                     err_unmatched_o, active_tiles_o, debug_state_o);
        end
        drive(1'b1, tile(2), NONE, 1'b0);
        drive(1'b1, NONE, tile(2), 1'b0);
        drive(1'b1, NONE, tile(9), 1'b1);
        observe();
        checks++;
        if (err_unmatched_o !== 1'b1 || err_dropped_o !== 1'b1) begin
            errors++;
            $display("FAIL errors_sticky: got eu=%b ed=%b required 1 1", err_unmatched_o, err_dropped_o);
        end
    endtask

    task automatic test_reset_mid_active();
        do_reset();
        drive(1'b1, tile(0), NONE, 1'b0);
        drive(1'b1, NONE, tile(0), 1'b0);
        drive(1'b1, NONE, NONE, 1'b1);
        drive(1'b1, tile(1) | tile(9), NONE, 1'b0);
        idle(3);
        drive(1'b0, NONE, NONE, 1'b0);
        observe();
        checks++;
        if ({toggle_start_o, toggle_stop_o, saif_en_o} !== 3'b0 || active_tiles_o !== 0 ||
            window_cycles_o !== 0 || window_id_o !== 0 || debug_state_o !== S_IDLE) begin
            errors++;
            $display("FAIL reset_mid_active: got pulses=%b cnt=%0d cyc=%0d id=%0d st=%0d required all 0",
                     {toggle_start_o, toggle_stop_o, saif_en_o}, active_tiles_o, window_cycles_o,
                     window_id_o, debug_state_o);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, NONE, NONE, 1'b0);
            observe();
            checks++;
            if (toggle_stop_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_stop: got stop=%b required 0", toggle_stop_o);
            end
        end
        drive(1'b1, tile(3), NONE, 1'b0);
        observe();
        checks++;
        if (toggle_start_o !== 1'b1 || window_id_o !== 0) begin
            errors++;
            $display("FAIL reset_new_window: got start=%b id=%0d required 1 0", toggle_start_o, window_id_o);
        end
        drive(1'b1, NONE, tile(3), 1'b0);
        drive(1'b1, NONE, NONE, 1'b1);
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b1, tile(11), NONE, 1'b0);
        idle(40);
        observe();
        checks++;
        if (window_cycles_o !== 5'd31) begin
            errors++;
            $display("FAIL cycles_saturate: got %0d required 31", window_cycles_o);
        end
        drive(1'b1, NONE, tile(11), 1'b0);
        drive(1'b1, NONE, NONE, 1'b1);
        idle(3);
        observe();
        checks++;
        if (window_cycles_o !== 5'd31) begin
            errors++;
            $display("FAIL cycles_hold: got %0d required 31", window_cycles_o);
        end
    endtask

    task automatic test_id_wrap();
        do_reset();
        for (int w = 0; w < 4; w++) begin
            drive(1'b1, tile(w), NONE, 1'b0);
            drive(1'b1, NONE, tile(w), 1'b0);
            drive(1'b1, NONE, NONE, 1'b1);
        end
        observe();
        checks++;
        if (window_id_o !== 2'd0) begin
            errors++;
            $display("FAIL id_wrap: got %0d required 0", window_id_o);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] s, e;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            s = N'($urandom) & N'($urandom) & N'($urandom);
            e = N'($urandom) & N'($urandom) & N'($urandom);
            drive(1'b1, s, e, ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_single_window();
        test_two_tiles();
        test_handover();
        test_simul_start_end();
        test_errors();
        test_reset_mid_active();
        test_saturation();
        test_id_wrap();
        test_random();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/saif_window_ctrl.md
SAIF_WINDOW_CTRL -- requirements
Module: saif_window_ctrl

Interface
REQ-001 SHALL have parameter num_tiles_p, default 16: number of tiles reporting SAIF triggers.
REQ-002 SHALL have parameter cycle_width_p, default 32: width of the window cycle counter.
REQ-003 SHALL have parameter window_id_width_p, default 8: width of the window index.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n_i, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port start_v_i, input, num_tiles_p: per-tile SAIF start-trigger pulse, bit i = tile i.
REQ-007 SHALL have port end_v_i, input, num_tiles_p: per-tile SAIF end-trigger pulse.
REQ-008 SHALL have port dump_done_i, input, 1: report writer finished writing the current window.
REQ-009 SHALL have port toggle_start_o, output, 1: one-cycle pulse that opens a capture window.
REQ-010 SHALL have port toggle_stop_o, output, 1: one-cycle pulse that closes the window and requests a dump.
REQ-011 SHALL have port saif_en_o, output, 1: level, high while in ACTIVE.
REQ-012 SHALL have port active_tiles_o, output, clog2(num_tiles_p+1): count of tiles currently inside a window.
REQ-013 SHALL have port window_cycles_o, output, cycle_width_p: cycles elapsed in the current or last window.
REQ-014 SHALL have port window_id_o, output, window_id_width_p: index of the current or last window.
REQ-015 SHALL have port err_unmatched_o, output, 1: sticky flag, end seen from a tile that was not active.
REQ-016 SHALL have port err_dropped_o, output, 1: sticky flag, start ignored during DUMP.

Function
REQ-017 SHALL keep a per-tile active bit vector; active_tiles_o SHALL be its registered popcount.
REQ-018 Tile i with start_v_i[i]=1, end_v_i[i]=0, and an inactive bit SHALL set its bit; a start from an already-active tile SHALL be ignored without error.
REQ-019 Tile i with end_v_i[i]=1, start_v_i[i]=0, and an active bit SHALL clear its bit; if the bit is inactive, err_unmatched_o SHALL set.
REQ-020 Tile i with start_v_i[i]=1 and end_v_i[i]=1 in the same cycle SHALL be a no-op for that tile, with no error.
REQ-021 The FSM SHALL have states IDLE, ACTIVE and DUMP.
REQ-022 In IDLE, if any bit is set by REQ-018, the FSM SHALL go to ACTIVE.
REQ-023 In ACTIVE, if the next-state active vector is all zero, the FSM SHALL go to DUMP.
REQ-024 In DUMP, when dump_done_i=1, the FSM SHALL go to IDLE and window_id_o SHALL increment, wrapping modulo 2^window_id_width_p.
REQ-025 toggle_start_o SHALL pulse for one cycle in the cycle after the IDLE->ACTIVE decision.
REQ-026 toggle_stop_o SHALL pulse for one cycle in the cycle after the ACTIVE->DUMP decision.
REQ-027 All outputs SHALL be registered, so latency from input to output is exactly 1 cycle.
REQ-028 In DUMP, start_v_i SHALL be ignored: the active vector is not changed and err_dropped_o sets.
REQ-029 In DUMP, end_v_i from any tile SHALL set err_unmatched_o.
REQ-030 In ACTIVE, an end from one tile and a start from another in the same cycle SHALL apply both, so the window stays open when the count stays nonzero.
REQ-031 window_cycles_o SHALL clear to 0 on IDLE->ACTIVE.
REQ-032 window_cycles_o SHALL increment by 1 per ACTIVE cycle, saturating at all-ones.
REQ-033 window_cycles_o SHALL hold its value in DUMP and IDLE.
REQ-034 dump_done_i SHALL be ignored outside DUMP.

Reset
REQ-035 When reset_n_i=0 at a clock edge, the following SHALL clear to 0 on that edge: FSM state (to IDLE), the active vector, all outputs, and both sticky errors.
REQ-036 Reset during ACTIVE or DUMP SHALL abort the window without issuing a toggle_stop_o pulse.
REQ-037 Only reset SHALL clear the sticky error flags.

Structure
REQ-038 The state enum saif_ctrl_state_e SHALL live in bsg_manycore_profile_pkg.
REQ-039 The popcount SHALL use the sub-module bsg_popcount; all other logic SHALL be flat.

Verification
REQ-040 Scenario: tile 3 starts at cycle 10 and ends at cycle 20 -> toggle_start_o high at cycle 11, toggle_stop_o high at cycle 21, window_cycles_o=10, window_id_o=0 until dump_done_i, then 1.
REQ-041 Scenario: tiles 0 and 5 start at cycle 0; tile 0 ends at cycle 4; tile 5 ends at cycle 9 -> exactly one start pulse and one stop pulse; active_tiles_o shows 2, then 1, then 0.
REQ-042 Scenario: in ACTIVE with only tile 1 active, tile 1 ends and tile 2 starts in the same cycle -> no stop pulse and active_tiles_o stays 1.
REQ-043 Scenario: tile 7 asserts start and end together while in IDLE -> no pulses, no error, FSM stays in IDLE.
REQ-044 Scenario: tile 4 starts while in DUMP, then tile 6 ends while in IDLE -> err_dropped_o=1, err_unmatched_o=1, active vector unchanged.
REQ-045 Scenario: reset_n_i=0 for one cycle mid-ACTIVE -> next cycle all outputs 0, no stop pulse, and a new start opens a window with window_id_o=0.
